// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 device-to-host receiver: receiver state
// encoding, frame length, default frame timeout and the odd-parity check.
// -----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS      = 11;
    // 200 us at 25 MHz
    localparam int DEFAULT_TIMEOUT = 5000;

    // Data bits plus the parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock circular FIFO with first-word fall-through head.
//
// Ports:
//   clk      in   system clock (rising edge)
//   rst      in   asynchronous reset, active-low
//   i_push   in   write request; taken when not full, or when full and a pop
//                 happens in the same cycle
//   i_data   in   write data
//   i_pop    in   read strobe; ignored while empty
//   o_head   out  oldest entry, 0 while empty
//   o_full   out  FIFO holds 2**DEPTH_LOG2 entries
//   o_empty  out  FIFO holds nothing
//   o_level  out  number of entries held
//   o_drop   out  a push was refused because the FIFO was full
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_pop,
    output logic [DATA_W-1:0]     o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_drop
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_level == (DEPTH_LOG2+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = i_pop & ~w_empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_push  = i_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;
    assign o_drop  = i_push & ~w_push;

endmodule

// File: rtl/ps2_rx_fifo.sv
// -----------------------------------------------------------------------------
// ps2_rx_fifo
// PS/2 device-to-host receiver: synchronises PS2C/PS2D, deframes 11-bit
// frames (start, d0..d7 LSB first, odd parity, stop), checks parity and stop
// bit and queues good bytes in a FIFO read by the I/O decoder.
//
// Ports:
//   clk      in   system clock (rising edge)
//   rst      in   asynchronous reset, active-low
//   ps2c     in   PS/2 clock, asynchronous to clk
//   ps2d     in   PS/2 data, asynchronous to clk
//   rd       in   pop strobe, one cycle per byte
//   clr_err  in   clears the sticky error flags
//   data     out  FIFO head byte (fall-through), 0 when empty
//   rdy      out  FIFO non-empty
//   level    out  bytes currently queued
//   ovf      out  sticky: good byte dropped because the FIFO was full
//   perr     out  sticky: parity error
//   ferr     out  sticky: stop bit was 0
// -----------------------------------------------------------------------------
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2c,
    input  logic                  ps2d,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic [7:0]            data,
    output logic                  rdy,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf,
    output logic                  perr,
    output logic                  ferr
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = 4;

    logic r_c_s1, r_c_s2, r_c_prev;
    logic r_d_s1, r_d_s2;

    ps2_state_t r_state;
    ps2_state_t w_state_nxt;

    logic [9:0]    r_shift;
    logic [BW-1:0] r_bitcnt;
    logic [TW-1:0] r_timer;

    logic r_ovf, r_perr, r_ferr;

    logic w_fall;
    logic w_check;
    logic w_stop_ok;
    logic w_par_ok;
    logic w_push;
    logic w_drop;
    logic w_empty;
    logic w_full;

    // ---- synchronisers + edge detect (idle bus resets to 1) ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_s1   <= 1'b1;
            r_c_s2   <= 1'b1;
            r_c_prev <= 1'b1;
            r_d_s1   <= 1'b1;
            r_d_s2   <= 1'b1;
        end else begin
            r_c_s1   <= ps2c;
            r_c_s2   <= r_c_s1;
            r_c_prev <= r_c_s2;
            r_d_s1   <= ps2d;
            r_d_s2   <= r_d_s1;
        end
    end

    // Data and clock have equal synchroniser depth, so r_d_s2 is the bit
    // that was on the wire when ps2c fell.
    assign w_fall = r_c_prev & ~r_c_s2;

    // ---- frame FSM ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_check     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && !r_d_s2) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Fall takes priority over an expiring timer.
                if (w_fall) begin
                    if (r_bitcnt == BW'(FRAME_BITS - 2)) begin
                        w_state_nxt = ST_CHECK;
                    end
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CHECK: begin
                w_check     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bitcnt <= '0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (w_fall) begin
                        r_bitcnt <= r_bitcnt + 1'b1;
                        r_timer  <= '0;
                    end else begin
                        r_timer  <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_bitcnt <= '0;
                    r_timer  <= '0;
                end
            endcase
        end
    end

    // Shift right so that after 10 bits: [7:0]=data, [8]=parity, [9]=stop.
    always_ff @(posedge clk) begin
        if (r_state == ST_SHIFT && w_fall) begin
            r_shift <= {r_d_s2, r_shift[9:1]};
        end
    end

    // ---- frame check + FIFO ----
    assign w_stop_ok = r_shift[9];
    assign w_par_ok  = odd_parity_ok(r_shift[8:0]);
    assign w_push    = w_check & w_stop_ok & w_par_ok;

    sync_fifo #(
        .DATA_W     (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_shift[7:0]),
        .i_pop   (rd),
        .o_head  (data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level),
        .o_drop  (w_drop)
    );

    // Sticky flags: a set in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovf  <= w_drop | (r_ovf & ~clr_err);
            r_perr <= (w_check & w_stop_ok & ~w_par_ok) | (r_perr & ~clr_err);
            r_ferr <= (w_check & ~w_stop_ok) | (r_ferr & ~clr_err);
        end
    end

    assign rdy  = ~w_empty;
    assign ovf  = r_ovf;
    assign perr = r_perr;
    assign ferr = r_ferr;

    // w_full is only needed inside the FIFO's accept logic.
    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

    localparam int DL = 4;
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic          ps2c;
    logic          ps2d;
    logic          rd;
    logic          clr_err;
    logic [7:0]    data;
    logic          rdy;
    logic [DL:0]   level;
    logic          ovf;
    logic          perr;
    logic          ferr;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of accepted bytes plus the three sticky flags.
    logic [7:0] m_q[$];
    logic       m_ovf  = 1'b0;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .DEPTH_LOG2 (DL),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2c    (ps2c),
        .ps2d    (ps2d),
        .rd      (rd),
        .clr_err (clr_err),
        .data    (data),
        .rdy     (rdy),
        .level   (level),
        .ovf     (ovf),
        .perr    (perr),
        .ferr    (ferr)
    );

    function automatic logic good_par(input logic [7:0] b);
        return ~(^b);
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop);
        if (!stop)                    m_ferr = 1'b1;
        else if ((^b ^ par) != 1'b1)  m_perr = 1'b1;
        else if (m_q.size() == 16)    m_ovf  = 1'b1;
        else                          m_q.push_back(b);
    endtask

    task automatic model_pop();
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    function automatic logic [7:0] m_head();
        return (m_q.size() > 0) ? m_q[0] : 8'h00;
    endfunction

    task automatic send_bit(input logic b);
        int h;
        int l;
        h = $urandom_range(3, 6);
        l = $urandom_range(3, 6);
        ps2d = b;
        repeat (h) @(negedge clk);
        ps2c = 1'b0;
        repeat (l) @(negedge clk);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        logic [10:0] f;
        f = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        ps2d = 1'b1;
        repeat (6) @(negedge clk);
        model_frame(b, par, stop);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        model_pop();
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rd = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (data  !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", data); end
        total++; if (rdy   !== 1'b0)  begin bad++; $display("FAIL rst_rdy got=%b exp=0", rdy); end
        total++; if (level !== 5'd0)  begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
        total++; if (ovf   !== 1'b0)  begin bad++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
        total++; if (perr  !== 1'b0)  begin bad++; $display("FAIL rst_perr got=%b exp=0", perr); end
        total++; if (ferr  !== 1'b0)  begin bad++; $display("FAIL rst_ferr got=%b exp=0", ferr); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency();
        logic [10:0] f;
        f = {1'b1, 1'b0, 8'h1C, 1'b0};
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        ps2d = 1'b1;
        repeat (4) @(negedge clk);
        ps2c = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL lat_early_rdy got=%b exp=0", rdy); end
        @(negedge clk);
        model_frame(8'h1C, 1'b0, 1'b1);
        total++; if (rdy   !== 1'b1)  begin bad++; $display("FAIL lat_rdy got=%b exp=1", rdy); end
        total++; if (data  !== 8'h1C) begin bad++; $display("FAIL lat_data got=%h exp=1c", data); end
        total++; if (level !== 5'd1)  begin bad++; $display("FAIL lat_level got=%0d exp=1", level); end
        repeat (3) @(negedge clk);
        ps2c = 1'b1;
        repeat (3) @(negedge clk);
        pulse_rd();
        total++; if (rdy  !== 1'b0)  begin bad++; $display("FAIL lat_pop_rdy got=%b exp=0", rdy); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL lat_pop_data got=%h exp=00", data); end
    endtask

    task automatic test_parity();
        send_frame(8'h1C, 1'b1, 1'b1);
        total++; if (perr !== m_perr) begin bad++; $display("FAIL par_perr got=%b exp=%b", perr, m_perr); end
        total++; if (rdy  !== 1'b0)   begin bad++; $display("FAIL par_rdy got=%b exp=0", rdy); end
        pulse_clr();
        total++; if (perr !== 1'b0)   begin bad++; $display("FAIL par_clr got=%b exp=0", perr); end
    endtask

    task automatic test_ferr_timeout();
        send_frame(8'h5A, good_par(8'h5A), 1'b0);
        total++; if (ferr  !== 1'b1) begin bad++; $display("FAIL fe_ferr got=%b exp=1", ferr); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL fe_level got=%0d exp=0", level); end
        pulse_clr();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        ps2d = 1'b1;
        repeat (TO + 10) @(negedge clk);
        send_frame(8'hA5, good_par(8'hA5), 1'b1);
        total++; if (data  !== 8'hA5) begin bad++; $display("FAIL to_data got=%h exp=a5", data); end
        total++; if (level !== 5'd1)  begin bad++; $display("FAIL to_level got=%0d exp=1", level); end
        total++; if ({perr, ferr} !== 2'b00) begin bad++; $display("FAIL to_flags got=%b%b exp=00", perr, ferr); end
        pulse_rd();
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        for (int i = 0; i < 17; i++) begin
            b = 8'(i);
            send_frame(b, good_par(b), 1'b1);
        end
        total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", level); end
        total++; if (ovf !== m_ovf)   begin bad++; $display("FAIL ovf_flag got=%b exp=%b", ovf, m_ovf); end
        for (int i = 0; i < 16; i++) begin
            total++; if (data !== m_head()) begin bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, data, m_head()); end
            pulse_rd();
        end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", rdy); end
        pulse_clr();
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
    endtask

    task automatic test_full_pop();
        logic [7:0]  b;
        logic [7:0]  last;
        logic [10:0] f;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            send_frame(b, good_par(b), 1'b1);
        end
        f = {1'b1, good_par(8'h55), 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        ps2d = 1'b1;
        repeat (4) @(negedge clk);
        ps2c = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (data !== m_head()) begin bad++; $display("FAIL fp_head got=%h exp=%h", data, m_head()); end
        pulse_rd();
        model_frame(8'h55, good_par(8'h55), 1'b1);
        repeat (3) @(negedge clk);
        ps2c = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (level !== 5'd16) begin bad++; $display("FAIL fp_level got=%0d exp=16", level); end
        total++; if (ovf !== 1'b0)    begin bad++; $display("FAIL fp_ovf got=%b exp=0", ovf); end
        last = 8'h00;
        for (int i = 0; i < 16; i++) begin
            total++; if (data !== m_head()) begin bad++; $display("FAIL fp_pop%0d got=%h exp=%h", i, data, m_head()); end
            last = data;
            pulse_rd();
        end
        total++; if (last !== 8'h55) begin bad++; $display("FAIL fp_last got=%h exp=55", last); end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        total++; if (level !== 5'd0) begin bad++; $display("FAIL fp_rd_empty got=%0d exp=0", level); end
        total++; if (rdy !== 1'b0)   begin bad++; $display("FAIL fp_rd_empty_rdy got=%b exp=0", rdy); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        logic [5:0] rest;
        b = 8'($urandom);
        send_frame(b, good_par(b), 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_q.delete(); m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        total++; if (data  !== 8'h00) begin bad++; $display("FAIL mr_data got=%h exp=00", data); end
        total++; if (rdy   !== 1'b0)  begin bad++; $display("FAIL mr_rdy got=%b exp=0", rdy); end
        total++; if (level !== 5'd0)  begin bad++; $display("FAIL mr_level got=%0d exp=0", level); end
        total++; if ({ovf, perr, ferr} !== 3'b000) begin bad++; $display("FAIL mr_flags got=%b%b%b exp=000", ovf, perr, ferr); end
        @(negedge clk);
        rst = 1'b1;
        rest = 6'b101111;
        for (int i = 0; i < 6; i++) send_bit(rest[i]);
        ps2d = 1'b1;
        repeat (TO + 20) @(negedge clk);
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL mr_garbage_rdy got=%b exp=0", rdy); end
        total++; if ({perr, ferr} !== 2'b00) begin bad++; $display("FAIL mr_garbage_flags got=%b%b exp=00", perr, ferr); end
        send_frame(8'h3C, good_par(8'h3C), 1'b1);
        total++; if (data !== 8'h3C) begin bad++; $display("FAIL mr_new_data got=%h exp=3c", data); end
        total++; if (rdy !== 1'b1)   begin bad++; $display("FAIL mr_new_rdy got=%b exp=1", rdy); end
        pulse_rd();
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         kind;
        for (int it = 0; it < 25; it++) begin
            kind = $urandom_range(0, 9);
            b = 8'($urandom);
            send_frame(b, good_par(b) ^ (kind == 8), (kind != 9));
            total++; if (level !== 5'(m_q.size())) begin bad++; $display("FAIL rnd%0d_level got=%0d exp=%0d", it, level, m_q.size()); end
            total++; if (data !== m_head()) begin bad++; $display("FAIL rnd%0d_data got=%h exp=%h", it, data, m_head()); end
            total++; if ({ovf, perr, ferr} !== {m_ovf, m_perr, m_ferr}) begin
                bad++; $display("FAIL rnd%0d_flags got=%b%b%b exp=%b%b%b", it, ovf, perr, ferr, m_ovf, m_perr, m_ferr);
            end
            if ($urandom_range(0, 2) == 0) pulse_rd();
            if ($urandom_range(0, 3) == 0) pulse_clr();
            total++; if (rdy !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd%0d_rdy got=%b exp=%b", it, rdy, (m_q.size() != 0)); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_parity();
        test_ferr_timeout();
        test_overflow();
        test_full_pop();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 receiver inside RISC5Top; directly downstream of the PS/2 keyboard/mouse pins driven by the PS2Dev model.
- Synchronises PS2C/PS2D, deframes 11-bit PS/2 device-to-host frames, and checks parity and stop bit.
- Queues good bytes in a FIFO read by the I/O decoder; one instance per PS/2 port (keyboard, mouse).

Parameters:
- DEPTH_LOG2, 4, FIFO holds 2**DEPTH_LOG2 bytes.
- TIMEOUT, 5000, clk cycles without a ps2c falling edge before a partial frame is discarded (200 us at 25 MHz).

Ports:
- clk  in  1  system clock (rising edge).
- rst  in  1  asynchronous reset, active-low.
- ps2c  in  1  PS/2 clock, asynchronous to clk.
- ps2d  in  1  PS/2 data, asynchronous to clk.
- rd  in  1  pop strobe, one cycle per byte.
- clr_err  in  1  clears sticky error flags.
- data  out  8  FIFO head byte (first-word fall-through).
- rdy  out  1  FIFO non-empty.
- level  out  DEPTH_LOG2+1  bytes currently queued.
- ovf  out  1  sticky: a good byte was dropped because the FIFO was full.
- perr  out  1  sticky: parity error.
- ferr  out  1  sticky: stop bit was 0.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; FIFO empty; data=0, rdy=0, level=0, ovf=perr=ferr=0. Synchronisers reset to 1 (idle bus).
- Synchronisation: ps2c and ps2d each pass through 2 flops; a third flop holds the previous ps2c sample.
  - fall = prev & ~sync.
  - The first clk edge that samples ps2c=0 is cycle 0; fall is high during cycle 2.
  - Data is sampled from synced ps2d in the same cycle as fall.
- Frame format: start(0), d0..d7 (LSB first), odd parity, stop(1).
- IDLE:
  - fall with ps2d=0 -> SHIFT, bitcnt=0, timer=0.
  - fall with ps2d=1 is ignored and the state stays IDLE.
- SHIFT:
  - Each fall shifts ps2d into a 10-bit register and increments bitcnt.
  - At bitcnt=10 (stop bit captured) -> CHECK.
  - timer resets on each fall and increments otherwise. At timer=TIMEOUT-1 -> IDLE; the partial frame is discarded and no flag is set.
- CHECK (exactly one cycle, then IDLE):
  - stop=0 -> ferr=1; byte discarded.
  - Otherwise, XOR of the 8 data bits and parity must be 1. If not, perr=1 and the byte is discarded.
  - Otherwise push.
  - A push when full sets ovf=1 and drops the byte, unless rd is asserted in the same cycle.
- Latency: rdy rises at cycle 4 relative to cycle 0 of the stop bit's falling ps2c (fall at 2, CHECK at 3, push visible at 4).
- FIFO:
  - Circular buffer; pointers are DEPTH_LOG2 bits and wrap modulo 2**DEPTH_LOG2.
  - level is a separate counter.
  - data shows the head entry combinationally when rdy=1, and 0 when empty.
  - rd while empty is ignored; level never underflows.
  - Simultaneous push and pop: level unchanged, both pointers advance. When full this is accepted and ovf is not set.
- Errors: ovf/perr/ferr cleared by clr_err. If a set and a clear coincide in the same cycle, set wins.
- Timing independence: no assumption on the ps2c/clk ratio beyond ps2c low/high phases lasting at least 3 clk each. Glitches shorter than that may be missed and are not required to be handled.
- Reset mid-frame: everything returns to reset values immediately. The remainder of the frame is then treated per IDLE rules; the 0-valued data bits may be taken as a new start bit, and the resulting garbage frame normally ends in perr/ferr or a timeout.

Decomposition:
- Shared package ps2_pkg:
  - State encoding (IDLE, SHIFT, CHECK).
  - FRAME_BITS=11.
  - Default TIMEOUT.
- One natural sub-module, sync_fifo: parameterised byte FIFO with push, pop, full, empty, level and fall-through head. Reusable for the RS232 receiver.
- Synchroniser and edge detect stay inline.

Test Plan:
- Send frame for byte 0x1C (data LSB first 0,0,1,1,1,0,0,0; parity 0; stop 1) -> rdy=1 exactly 4 clk after the stop edge, data=0x1C, level=1. Pulse rd -> rdy=0, data=0.
- Same frame with parity bit 1 -> perr=1, rdy stays 0. Pulse clr_err -> perr=0.
- Frame with stop=0 -> ferr=1, nothing queued. Send a frame holding only 5 bits, then idle for TIMEOUT cycles -> back to IDLE. Next good byte 0xA5 is received correctly.
- Send 17 good bytes 0x00..0x10 without reading (DEPTH_LOG2=4) -> level=16, ovf=1. Pops return 0x00..0x0F in order, then rdy=0.
- FIFO full and rd asserted in the CHECK cycle of byte 0x55 -> level stays 16, ovf stays 0, 0x55 is the last byte popped. rd on empty FIFO -> level stays 0.
- Drop rst (0) after 4 data bits of a frame -> all outputs 0 immediately. With rst released before the next bit and the remaining bits 1,1,1,1,0,1 (leftover data, parity, stop), rdy stays 0 until a new full frame 0x3C -> data=0x3C.
